likelihood_accum_seq: RTL
=========================

// Module: likelihood_accum_seq
// PURPOSE
// Parametrised successor of the single-array log2 likelihood slice. Sequences NOBS observation reads over NCH
// hypothesis columns of an external likelihood memory, sums stored -log2 costs onto per-channel priors with
// saturation, and reports posterior costs plus the best (minimum-cost) hypothesis. Also arbitrates single-word
// programming writes. Sits between the inference controller and the memory-array wrapper.
// PARAMETERS
// NWORD  3  row address bits (2**NWORD rows)
// W      8  cost width; unsigned -log2 likelihood magnitude
// NCH    2  hypothesis channels (memory columns), >=2
// NOBS   4  observations per inference, >=1
// PORTS
// clk         in   1            clock
// rst         in   1            asynchronous, active-high reset
// start       in   1            begin inference (sampled in IDLE only)
// obs_addr    in   NOBS*NWORD   row per observation, obs i at [i*NWORD +: NWORD]
// prior_in    in   NCH*W        prior cost per channel, sampled with start
// prog_req    in   1            program request (level, held until prog_ack)
// prog_row    in   NWORD        program row
// prog_ch     in   $clog2(NCH)  program column
// prog_data   in   W            program word
// prog_ack    out  1            1-cycle pulse: write completed
// mem_req     out  1            memory access request
// mem_we      out  1            1=write, 0=read
// mem_row     out  NWORD        access row
// mem_col     out  $clog2(NCH)  access column
// mem_wdata   out  W            write data
// mem_ack     in   1            access complete (may be combinational from mem_req)
// mem_rdata   in   W            read data, valid when mem_req&mem_ack&!mem_we
// busy        out  1            state != IDLE
// post_valid  out  1            1-cycle pulse: posterior outputs valid
// post_cost   out  NCH*W        accumulated cost per channel (held until next start)
// post_best   out  $clog2(NCH)  argmin of post_cost, ties -> lowest index
// post_sat    out  NCH          channel saturated during this inference
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0, including post_cost, post_best, post_sat; counters cleared.
// - States: IDLE, PROG, READ, DONE.
// - IDLE: start=1 -> acc[c]<=prior_in[c], sat<=0, obs=0, ch=0, -> READ. Else prog_req=1 -> PROG.
//   start has priority over prog_req in the same cycle; prog_req stays pending.
// - PROG: mem_req=1, mem_we=1, row/col/wdata = prog_* (registered on entry, stable).
//   On mem_ack: prog_ack pulse next cycle, -> IDLE.
// - READ: mem_req=1, mem_we=0, mem_row=obs_addr[obs], mem_col=ch; stable until mem_ack.
//   On mem_req&mem_ack: acc[ch]<=sat_add(acc[ch],mem_rdata); ch increments first, then obs.
//   After access (obs=NOBS-1, ch=NCH-1) -> DONE.
// - sat_add: W+1-bit sum; if carry then 2**W-1 and sat[ch]<=1. Saturated acc stays at max.
// - DONE: post_valid=1 for one cycle; post_cost/post_best/post_sat update on the same edge; -> IDLE.
// - Latency with mem_ack tied high: post_valid in cycle NOBS*NCH+1 after the start cycle.
//   Each cycle of mem_ack low adds one cycle.
// - start or prog_req outside IDLE is ignored. obs_addr is re-sampled per access; hold it stable while busy.
// - mem_ack without mem_req is ignored. Mid-operation reset returns to IDLE at once.
//   mem_req drops asynchronously, and no partial posterior or prog_ack is emitted.
// STRUCTURE
// - Package likelihood_pkg: state enum lk_state_e, function sat_add(W), localparam CH_W=$clog2(NCH).
// - Sub-module argmin_nch #(NCH,W): combinational min-cost index, lowest index on tie.
//   The top registers its output in DONE.
// - All other logic (FSM, obs/ch counters, accumulator array, prog path) lives in this module.
// TESTING (NWORD=3, W=8, NCH=2, NOBS=4; memory model acks same cycle unless stated)
// 1 Reset held, then released with no stimulus -> all outputs 0; busy=0.
// 2 prior={10,20}, memory returns ch0=5, ch1=1 for every row, start at cycle 0
//   -> post_valid at cycle 9; post_cost={30,24}; post_best=1; post_sat=0.
// 3 prior={250,0}, rdata=3 everywhere -> post_cost[0]=255, post_sat=2'b01, post_best=1.
// 4 Ties: prior={7,7}, rdata=0 -> post_best=0. Distinct obs_addr {1,6,3,5}
//   -> mem_row sequence 1,1,6,6,3,3,5,5 with mem_col 0,1,0,1,...
// 5 mem_ack asserted on the 4th cycle of each request -> mem_row/mem_col stable while waiting;
//   post_valid at cycle 33; results identical to scenario 2.
// 6 prog_req row=5, ch=1, data=8'hA5 with start pulsed during PROG -> mem_we=1, mem_row=5, mem_col=1,
//   mem_wdata=A5 until ack; prog_ack 1 cycle; start ignored. Then rst mid-READ -> IDLE, no post_valid.

Source files
------------

// File: rtl/likelihood_pkg.sv
// likelihood_pkg: shared state encoding, default geometry and saturating add for the likelihood accumulator
package likelihood_pkg;
  localparam int LK_NWORD = 3;
  localparam int LK_W = 8;
  localparam int LK_NCH = 2;
  localparam int LK_NOBS = 4;
  localparam int CH_W = $clog2(LK_NCH);
  typedef enum logic [1:0] {ST_IDLE, ST_PROG, ST_READ, ST_DONE} lk_state_e;
  // Adds two w-bit costs; clamps to 2**w-1 and flags carry when the true sum overflows w bits
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w, output logic carry);
    logic [32:0] s;
    logic [32:0] mx;
    s = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    carry = s > mx;
    return carry ? mx[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/likelihood_accum_seq_argmin.sv
// argmin_nch: combinational index of the minimum cost, lowest index wins ties
module argmin_nch #(
  parameter int NCH = 2,
  parameter int W = 8
)(
  input  logic [NCH*W-1:0]        cost,
  output logic [$clog2(NCH)-1:0]  idx
);
  localparam int CW = $clog2(NCH);
  logic [W-1:0] min_c;
  // Strict less-than keeps the earliest channel on equal costs
  always_comb begin
    idx = '0;
    min_c = cost[W-1:0];
    for (int i = 1; i < NCH; i++)
      if (cost[i*W +: W] < min_c) begin
        min_c = cost[i*W +: W];
        idx = CW'(i);
      end
  end
endmodule

// File: rtl/likelihood_accum_seq.sv
// likelihood_accum_seq: sequences observation reads over hypothesis columns, accumulates saturating costs, reports argmin
module likelihood_accum_seq import likelihood_pkg::*; #(
  parameter int NWORD = LK_NWORD,
  parameter int W = LK_W,
  parameter int NCH = LK_NCH,
  parameter int NOBS = LK_NOBS
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NOBS*NWORD-1:0]   obs_addr,
  input  logic [NCH*W-1:0]        prior_in,
  input  logic                    prog_req,
  input  logic [NWORD-1:0]        prog_row,
  input  logic [$clog2(NCH)-1:0]  prog_ch,
  input  logic [W-1:0]            prog_data,
  output logic                    prog_ack,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [NWORD-1:0]        mem_row,
  output logic [$clog2(NCH)-1:0]  mem_col,
  output logic [W-1:0]            mem_wdata,
  input  logic                    mem_ack,
  input  logic [W-1:0]            mem_rdata,
  output logic                    busy,
  output logic                    post_valid,
  output logic [NCH*W-1:0]        post_cost,
  output logic [$clog2(NCH)-1:0]  post_best,
  output logic [NCH-1:0]          post_sat
);
  localparam int CW = $clog2(NCH);
  localparam int OW = NOBS > 1 ? $clog2(NOBS) : 1;
  lk_state_e state;
  logic [OW-1:0] obs;
  logic [CW-1:0] ch;
  logic [W-1:0] acc [NCH];
  logic [NCH-1:0] sat, sat_nx;
  logic [NCH*W-1:0] acc_nx;
  logic [NWORD-1:0] p_row;
  logic [CW-1:0] p_ch;
  logic [W-1:0] p_data;
  logic [W-1:0] sum;
  logic carry;
  logic [CW-1:0] best;
  logic rd_fire, last;
  assign mem_req = state == ST_PROG || state == ST_READ;
  assign mem_we = state == ST_PROG;
  assign mem_row = state == ST_PROG ? p_row : state == ST_READ ? obs_addr[int'(obs)*NWORD +: NWORD] : '0;
  assign mem_col = state == ST_PROG ? p_ch : state == ST_READ ? ch : '0;
  assign mem_wdata = mem_we ? p_data : '0;
  assign busy = state != ST_IDLE;
  assign post_valid = state == ST_DONE;
  assign rd_fire = state == ST_READ && mem_ack;
  assign last = obs == OW'(NOBS-1) && ch == CW'(NCH-1);
  // Next accumulator view including the read completing this cycle, so the final edge can latch results directly
  always_comb begin
    carry = 1'b0;
    sum = W'(sat_add(32'(acc[ch]), 32'(mem_rdata), W, carry));
    for (int c = 0; c < NCH; c++) begin
      acc_nx[c*W +: W] = rd_fire && ch == CW'(c) ? sum : acc[c];
      sat_nx[c] = sat[c] | (rd_fire && ch == CW'(c) && carry);
    end
  end
  argmin_nch #(.NCH(NCH), .W(W)) u_argmin (
    .cost(acc_nx),
    .idx (best)
  );
  // Control FSM, channel-then-observation counters, accumulators, program capture and posterior registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      obs <= '0;
      ch <= '0;
      sat <= '0;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
      p_row <= '0;
      p_ch <= '0;
      p_data <= '0;
      prog_ack <= 1'b0;
      post_cost <= '0;
      post_best <= '0;
      post_sat <= '0;
    end else begin
      prog_ack <= state == ST_PROG && mem_ack;
      for (int c = 0; c < NCH; c++) acc[c] <= acc_nx[c*W +: W];
      sat <= sat_nx;
      case (state)
        ST_IDLE:
          if (start) begin
            for (int c = 0; c < NCH; c++) acc[c] <= prior_in[c*W +: W];
            sat <= '0;
            obs <= '0;
            ch <= '0;
            state <= ST_READ;
          end else if (prog_req && !prog_ack) begin
            p_row <= prog_row;
            p_ch <= prog_ch;
            p_data <= prog_data;
            state <= ST_PROG;
          end
        ST_PROG: if (mem_ack) state <= ST_IDLE;
        ST_READ:
          if (mem_ack) begin
            ch <= ch == CW'(NCH-1) ? '0 : ch + CW'(1);
            if (ch == CW'(NCH-1)) obs <= obs + OW'(1);
            if (last) begin
              state <= ST_DONE;
              post_cost <= acc_nx;
              post_best <= best;
              post_sat <= sat_nx;
            end
          end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
